// File: rtl/frame_sync_gen_if.sv
// Control and video-timing bundle between frame_sync_gen (master) and its controller/monitor (slave).
interface frame_sync_gen_if;
    logic        Start;
    logic        Stop;
    logic [10:0] Frame_Num;
    logic        Busy;
    logic        Done;
    logic        Sync_0;
    logic        Hsync;
    logic        De;
    logic [23:0] Pix_Data;
    logic [10:0] Frame_O_Cnt;

    modport master (
        input  Start, Stop, Frame_Num,
        output Busy, Done, Sync_0, Hsync, De, Pix_Data, Frame_O_Cnt
    );

    modport slave (
        output Start, Stop, Frame_Num,
        input  Busy, Done, Sync_0, Hsync, De, Pix_Data, Frame_O_Cnt
    );
endinterface

// File: rtl/frame_sync_gen.sv
// Programmable video-timing generator: Sync_0/Hsync/De for a run of N frames or continuous streaming.
// Define FRAME_SYNC_GEN_PATTERN_EN for 8 vertical colour bars on Pix_Data; otherwise Pix_Data is 0.
module frame_sync_gen #(
    parameter int unsigned H_SYNC   = 40,
    parameter int unsigned H_BP     = 220,
    parameter int unsigned H_ACTIVE = 1280,
    parameter int unsigned H_FP     = 110,
    parameter int unsigned V_SYNC   = 5,
    parameter int unsigned V_BP     = 20,
    parameter int unsigned V_ACTIVE = 720,
    parameter int unsigned V_FP     = 5
) (
    input  logic             Clk_0,
    input  logic             Rst_n,
    frame_sync_gen_if.master bus
);
    localparam int unsigned H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int unsigned V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int unsigned HW      = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    localparam int unsigned VW      = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
    localparam int unsigned HX      = HW + 1;
    localparam int unsigned VX      = VW + 1;
    localparam int unsigned FW      = 11;

    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    // Window bounds carry one spare bit so an exclusive end equal to the total still fits.
    localparam logic [HX-1:0] H_SYNC_END = HX'(H_SYNC);
    localparam logic [HX-1:0] H_ACT_BEG  = HX'(H_SYNC + H_BP);
    localparam logic [HX-1:0] H_ACT_END  = HX'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [VX-1:0] V_SYNC_END = VX'(V_SYNC);
    localparam logic [VX-1:0] V_ACT_BEG  = VX'(V_SYNC + V_BP);
    localparam logic [VX-1:0] V_ACT_END  = VX'(V_SYNC + V_BP + V_ACTIVE);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;
    logic [FW-1:0] run_cnt_q, run_cnt_d;
    logic [FW-1:0] frame_num_q, frame_num_d;
    logic [FW-1:0] frame_o_cnt_q, frame_o_cnt_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          sync_q, sync_d;
    logic          hsync_q, hsync_d;
    logic          de_q, de_d;

    logic          running;
    logic          line_end;
    logic          frame_end;
    logic          last_frame;
    logic [HX-1:0] h_ext;
    logic [VX-1:0] v_ext;

    // Next-state, counter and decode logic.
    always_comb begin
        state_d       = state_q;
        h_cnt_d       = h_cnt_q;
        v_cnt_d       = v_cnt_q;
        run_cnt_d     = run_cnt_q;
        frame_num_d   = frame_num_q;
        frame_o_cnt_d = frame_o_cnt_q;
        done_d        = 1'b0;

        running    = (state_q != IDLE);
        h_ext      = {1'b0, h_cnt_q};
        v_ext      = {1'b0, v_cnt_q};
        line_end   = (h_cnt_q == H_LAST);
        frame_end  = line_end && (v_cnt_q == V_LAST);
        last_frame = (frame_num_q != '0) && (FW'(run_cnt_q + FW'(1)) == frame_num_q);

        sync_d  = running && (v_ext < V_SYNC_END);
        hsync_d = running && (h_ext < H_SYNC_END);
        de_d    = running && (h_ext >= H_ACT_BEG) && (h_ext < H_ACT_END)
                          && (v_ext >= V_ACT_BEG) && (v_ext < V_ACT_END);

        case (state_q)
            IDLE: begin
                h_cnt_d = '0;
                v_cnt_d = '0;
                if (bus.Start) begin
                    state_d     = RUN;
                    frame_num_d = bus.Frame_Num;
                    run_cnt_d   = '0;
                end
            end
            RUN, DRAIN: begin
                if ((state_q == RUN) && bus.Stop) begin
                    state_d = DRAIN;
                end
                if (line_end) begin
                    h_cnt_d = '0;
                    v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + VW'(1);
                end else begin
                    h_cnt_d = h_cnt_q + HW'(1);
                end
                // A Stop landing on the frame-end cycle still lets this frame finish and ends the run.
                if (frame_end) begin
                    frame_o_cnt_d = frame_o_cnt_q + FW'(1);
                    run_cnt_d     = run_cnt_q + FW'(1);
                    if ((state_d == DRAIN) || last_frame) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

`ifdef FRAME_SYNC_GEN_PATTERN_EN
    localparam int unsigned BAR_W = (H_ACTIVE >= 8) ? (H_ACTIVE / 8) : 1;

    logic [23:0]   pix_q, pix_d;
    logic [HX-1:0] px_off;
    logic [HX-1:0] bar_idx;

    // Colour-bar lookup; remainder pixels past the eighth bar fall into black.
    always_comb begin
        px_off  = h_ext - H_ACT_BEG;
        bar_idx = px_off / HX'(BAR_W);
        pix_d   = 24'h000000;
        if (de_d) begin
            case (bar_idx)
                HX'(0):  pix_d = 24'hFFFFFF;
                HX'(1):  pix_d = 24'hFFFF00;
                HX'(2):  pix_d = 24'h00FFFF;
                HX'(3):  pix_d = 24'h00FF00;
                HX'(4):  pix_d = 24'hFF00FF;
                HX'(5):  pix_d = 24'hFF0000;
                HX'(6):  pix_d = 24'h0000FF;
                default: pix_d = 24'h000000;
            endcase
        end
    end
`endif

    always_ff @(posedge Clk_0 or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q       <= IDLE;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            run_cnt_q     <= '0;
            frame_num_q   <= '0;
            frame_o_cnt_q <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            sync_q        <= 1'b0;
            hsync_q       <= 1'b0;
            de_q          <= 1'b0;
`ifdef FRAME_SYNC_GEN_PATTERN_EN
            pix_q         <= '0;
`endif
        end else begin
            state_q       <= state_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            run_cnt_q     <= run_cnt_d;
            frame_num_q   <= frame_num_d;
            frame_o_cnt_q <= frame_o_cnt_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            sync_q        <= sync_d;
            hsync_q       <= hsync_d;
            de_q          <= de_d;
`ifdef FRAME_SYNC_GEN_PATTERN_EN
            pix_q         <= pix_d;
`endif
        end
    end

    assign bus.Busy        = busy_q;
    assign bus.Done        = done_q;
    assign bus.Sync_0      = sync_q;
    assign bus.Hsync       = hsync_q;
    assign bus.De          = de_q;
    assign bus.Frame_O_Cnt = frame_o_cnt_q;
`ifdef FRAME_SYNC_GEN_PATTERN_EN
    assign bus.Pix_Data    = pix_q;
`else
    assign bus.Pix_Data    = 24'h000000;
`endif

endmodule

// File: tb/tb_frame_sync_gen.sv
// Bench for frame_sync_gen on a reduced 14x7 raster, checked against a pixel-index reference model.
module tb_frame_sync_gen;
    localparam int HS = 2, HBP = 2, HA = 8, HFP = 2;
    localparam int VS = 1, VBP = 1, VA = 4, VFP = 1;
    localparam int HT = HS + HBP + HA + HFP;
    localparam int VT = VS + VBP + VA + VFP;
    localparam int FL = HT * VT;
    localparam int MAX_CYC = 4 * FL + 10;
`ifdef FRAME_SYNC_GEN_PATTERN_EN
    localparam logic [23:0] EXP_P0 = 24'hFFFFFF;
    localparam logic [23:0] EXP_P1 = 24'hFFFF00;
`else
    localparam logic [23:0] EXP_P0 = 24'h000000;
    localparam logic [23:0] EXP_P1 = 24'h000000;
`endif

    logic Clk_0 = 1'b0;
    logic Rst_n = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;
    logic [10:0] sent = '0;

    frame_sync_gen_if bus ();

    frame_sync_gen #(
        .H_SYNC(HS), .H_BP(HBP), .H_ACTIVE(HA), .H_FP(HFP),
        .V_SYNC(VS), .V_BP(VBP), .V_ACTIVE(VA), .V_FP(VFP)
    ) dut (
        .Clk_0(Clk_0),
        .Rst_n(Rst_n),
        .bus  (bus)
    );

    always #5 Clk_0 = ~Clk_0;

    // Reference model: position in the frame is a single pixel index 0..FL-1.
    bit          m_run, m_stopping, e_done, e_sync, e_hsync, e_de;
    int          m_pix;
    logic [10:0] m_fn, m_frames, m_cnt;
    logic [23:0] e_pix;

    function automatic bit in_sync(int p);
        return (p / HT) < VS;
    endfunction

    function automatic bit in_hsync(int p);
        return (p % HT) < HS;
    endfunction

    function automatic bit in_de(int p);
        int h = p % HT;
        int v = p / HT;
        return (h >= HS + HBP) && (h < HS + HBP + HA) && (v >= VS + VBP) && (v < VS + VBP + VA);
    endfunction

    function automatic logic [23:0] bar_of(int p);
        int idx = ((p % HT) - (HS + HBP)) / ((HA >= 8) ? HA / 8 : 1);
        logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                  24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
        if (idx > 7) idx = 7;
`ifdef FRAME_SYNC_GEN_PATTERN_EN
        return bars[idx];
`else
        return (bars[idx] & 24'h000000);
`endif
    endfunction

    always @(posedge Clk_0 or negedge Rst_n) begin
        if (!Rst_n) begin
            m_run <= 0; m_stopping <= 0; m_pix <= 0; m_fn <= '0; m_frames <= '0; m_cnt <= '0;
            e_done <= 0; e_sync <= 0; e_hsync <= 0; e_de <= 0; e_pix <= '0;
        end else begin
            e_sync  <= m_run && in_sync(m_pix);
            e_hsync <= m_run && in_hsync(m_pix);
            e_de    <= m_run && in_de(m_pix);
            e_pix   <= (m_run && in_de(m_pix)) ? bar_of(m_pix) : 24'h0;
            e_done  <= 1'b0;
            if (!m_run) begin
                if (bus.Start) begin
                    m_run <= 1; m_stopping <= 0; m_fn <= bus.Frame_Num; m_frames <= '0; m_pix <= 0;
                end
            end else begin
                if (bus.Stop) m_stopping <= 1;
                if (m_pix == FL - 1) begin
                    m_pix    <= 0;
                    m_cnt    <= m_cnt + 11'd1;
                    m_frames <= m_frames + 11'd1;
                    if (m_stopping || bus.Stop || (m_fn != 0 && m_frames + 11'd1 == m_fn)) begin
                        m_run  <= 0;
                        e_done <= 1;
                    end
                end else begin
                    m_pix <= m_pix + 1;
                end
            end
        end
    end

    function automatic logic [39:0] dut_vec();
        return {bus.Busy, bus.Done, bus.Sync_0, bus.Hsync, bus.De, bus.Pix_Data, bus.Frame_O_Cnt};
    endfunction

    function automatic logic [39:0] exp_vec();
        return {m_run, e_done, e_sync, e_hsync, e_de, e_pix, m_cnt};
    endfunction

    // Called at a falling edge; drives inputs for the next rising edge and returns at the following falling edge.
    task automatic tick(input logic st, input logic sp);
        bus.Start = st;
        bus.Stop  = sp;
        @(posedge Clk_0);
        @(negedge Clk_0);
        bus.Start = 1'b0;
        bus.Stop  = 1'b0;
    endtask

    // Starts a run and records what the outputs did; stop_at is the pixel index on which Stop is sampled.
    task automatic watch(input logic [10:0] fn, input bit with_stop, input int stop_at, input bit noise,
                         output int done_c, output int n_done, output int rises, output int first_rise,
                         output int bad_gap, output int bad_width, output int model_mm,
                         output int busy0, output int busy_end);
        int last_rise, width, tail;
        logic st, sp;
        done_c = -1; n_done = 0; rises = 0; first_rise = -1; bad_gap = 0; bad_width = 0;
        model_mm = 0; last_rise = 0; width = 0; tail = -1;
        bus.Frame_Num = fn;
        tick(1'b1, with_stop);
        busy0 = int'(bus.Busy);
        if (dut_vec() !== exp_vec()) model_mm++;
        for (int c = 1; c <= MAX_CYC && tail != 0; c++) begin
            st = noise && (done_c < 0) && ($urandom_range(0, 5) == 0);
            sp = (done_c < 0) && ((c == stop_at + 1) ||
                 (noise && stop_at >= 0 && c > stop_at + 1 && $urandom_range(0, 3) == 0));
            if (noise && done_c < 0) bus.Frame_Num = 11'($urandom);
            tick(st, sp);
            if (dut_vec() !== exp_vec()) model_mm++;
            if (bus.Sync_0) begin
                if (width == 0) begin
                    rises++;
                    if (first_rise < 0) first_rise = c;
                    else if (c - last_rise != FL) bad_gap++;
                    last_rise = c;
                end
                width++;
            end else begin
                if (width != 0 && width != HT * VS) bad_width++;
                width = 0;
            end
            if (bus.Done) begin
                n_done++;
                if (done_c < 0) begin done_c = c; tail = 3; end
            end else if (tail > 0) begin
                tail--;
            end
        end
        busy_end = int'(bus.Busy);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge Clk_0);
        n_checks++; if (dut_vec() !== 40'h0) $display("FAIL reset_outputs got=%h required=0", dut_vec()); else n_pass++;
        Rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(1'b0, 1'b0);
            n_checks++;
            if (dut_vec() !== 40'h0) $display("FAIL idle_outputs cyc=%0d got=%h required=0", i, dut_vec()); else n_pass++;
        end
    endtask

    task automatic test_fixed_run();
        int dc, nd, rs, fr, bg, bw, mm, b0, be;
        watch(11'd3, 1'b0, -1, 1'b0, dc, nd, rs, fr, bg, bw, mm, b0, be);
        sent = sent + 11'd3;
        n_checks++; if (mm != 0)  $display("FAIL fixed_model bad_cycles=%0d required=0", mm); else n_pass++;
        n_checks++; if (b0 != 1)  $display("FAIL fixed_busy_start got=%0d required=1", b0); else n_pass++;
        n_checks++; if (fr != 1)  $display("FAIL fixed_first_rise got=%0d required=1", fr); else n_pass++;
        n_checks++; if (rs != 3)  $display("FAIL fixed_rises got=%0d required=3", rs); else n_pass++;
        n_checks++; if (bg != 0)  $display("FAIL fixed_spacing bad=%0d required=0", bg); else n_pass++;
        n_checks++; if (bw != 0)  $display("FAIL fixed_width bad=%0d required=0", bw); else n_pass++;
        n_checks++; if (dc != 3 * FL) $display("FAIL fixed_done_cycle got=%0d required=%0d", dc, 3 * FL); else n_pass++;
        n_checks++; if (nd != 1)  $display("FAIL fixed_done_pulses got=%0d required=1", nd); else n_pass++;
        n_checks++; if (be != 0)  $display("FAIL fixed_busy_end got=%0d required=0", be); else n_pass++;
        n_checks++; if (bus.Frame_O_Cnt !== sent) $display("FAIL fixed_frame_cnt got=%0d required=%0d", bus.Frame_O_Cnt, sent); else n_pass++;
    endtask

    task automatic test_stop();
        int dc, nd, rs, fr, bg, bw, mm, b0, be, sa;
        for (int k = 0; k < 2; k++) begin
            sa = (k == 0) ? int'($urandom_range(FL, 2 * FL - 1)) : 2 * FL - 1;
            watch(11'd0, 1'b0, sa, (k == 0), dc, nd, rs, fr, bg, bw, mm, b0, be);
            sent = sent + 11'd2;
            n_checks++; if (mm != 0) $display("FAIL stop_model k=%0d bad_cycles=%0d required=0", k, mm); else n_pass++;
            n_checks++; if (rs != 2) $display("FAIL stop_rises k=%0d got=%0d required=2", k, rs); else n_pass++;
            n_checks++; if (dc != 2 * FL) $display("FAIL stop_done_cycle k=%0d got=%0d required=%0d", k, dc, 2 * FL); else n_pass++;
            n_checks++; if (nd != 1) $display("FAIL stop_done_pulses k=%0d got=%0d required=1", k, nd); else n_pass++;
            n_checks++; if (bus.Frame_O_Cnt !== sent) $display("FAIL stop_frame_cnt k=%0d got=%0d required=%0d", k, bus.Frame_O_Cnt, sent); else n_pass++;
        end
    endtask

    task automatic test_start_ignored();
        int dc, nd, rs, fr, bg, bw, mm, b0, be;
        watch(11'd2, 1'b0, -1, 1'b1, dc, nd, rs, fr, bg, bw, mm, b0, be);
        sent = sent + 11'd2;
        n_checks++; if (mm != 0) $display("FAIL restart_model bad_cycles=%0d required=0", mm); else n_pass++;
        n_checks++; if (rs != 2 || bg != 0) $display("FAIL restart_rises got=%0d gaps_bad=%0d required=2/0", rs, bg); else n_pass++;
        n_checks++; if (dc != 2 * FL) $display("FAIL restart_done_cycle got=%0d required=%0d", dc, 2 * FL); else n_pass++;
        n_checks++; if (bus.Frame_O_Cnt !== sent) $display("FAIL restart_frame_cnt got=%0d required=%0d", bus.Frame_O_Cnt, sent); else n_pass++;
    endtask

    task automatic test_start_stop_idle();
        int dc, nd, rs, fr, bg, bw, mm, b0, be;
        watch(11'd1, 1'b1, -1, 1'b0, dc, nd, rs, fr, bg, bw, mm, b0, be);
        sent = sent + 11'd1;
        n_checks++; if (mm != 0) $display("FAIL startstop_model bad_cycles=%0d required=0", mm); else n_pass++;
        n_checks++; if (b0 != 1 || fr != 1) $display("FAIL startstop_begin busy=%0d first_rise=%0d required=1/1", b0, fr); else n_pass++;
        n_checks++; if (dc != FL || rs != 1) $display("FAIL startstop_done cycle=%0d rises=%0d required=%0d/1", dc, rs, FL); else n_pass++;
        n_checks++; if (bus.Frame_O_Cnt !== sent) $display("FAIL startstop_frame_cnt got=%0d required=%0d", bus.Frame_O_Cnt, sent); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int dc, nd, rs, fr, bg, bw, mm, b0, be;
        bus.Frame_Num = 11'd2;
        tick(1'b1, 1'b0);
        repeat ($urandom_range(FL + 10, FL + 60)) tick(1'b0, 1'b0);
        #2 Rst_n = 1'b0;
        #1;
        n_checks++; if (dut_vec() !== 40'h0) $display("FAIL midreset_immediate got=%h required=0", dut_vec()); else n_pass++;
        @(negedge Clk_0);
        n_checks++; if (dut_vec() !== 40'h0) $display("FAIL midreset_held got=%h required=0", dut_vec()); else n_pass++;
        Rst_n = 1'b1;
        sent = '0;
        watch(11'd1, 1'b0, -1, 1'b0, dc, nd, rs, fr, bg, bw, mm, b0, be);
        sent = sent + 11'd1;
        n_checks++; if (mm != 0) $display("FAIL midreset_model bad_cycles=%0d required=0", mm); else n_pass++;
        n_checks++; if (fr != 1 || rs != 1 || bw != 0) $display("FAIL midreset_frame first=%0d rises=%0d badw=%0d required=1/1/0", fr, rs, bw); else n_pass++;
        n_checks++; if (dc != FL) $display("FAIL midreset_done_cycle got=%0d required=%0d", dc, FL); else n_pass++;
        n_checks++; if (bus.Frame_O_Cnt !== sent) $display("FAIL midreset_frame_cnt got=%0d required=%0d", bus.Frame_O_Cnt, sent); else n_pass++;
    endtask

    task automatic test_pattern();
        int de_cnt, dl, bad_line, pix_bad, p0_bad, p1_bad, p7_bad, mm;
        de_cnt = 0; dl = 0; bad_line = 0; pix_bad = 0; p0_bad = 0; p1_bad = 0; p7_bad = 0; mm = 0;
        bus.Frame_Num = 11'd1;
        tick(1'b1, 1'b0);
        for (int c = 1; c <= FL + 3; c++) begin
            tick(1'b0, 1'b0);
            if (dut_vec() !== exp_vec()) mm++;
            if (bus.De) begin
                de_cnt++;
                if (dl == 0 && bus.Pix_Data !== EXP_P0) p0_bad++;
                if (dl == 1 && bus.Pix_Data !== EXP_P1) p1_bad++;
                if (dl == 7 && bus.Pix_Data !== 24'h000000) p7_bad++;
                dl++;
            end else begin
                if (dl != 0 && dl != HA) bad_line++;
                if (bus.Pix_Data !== 24'h000000) pix_bad++;
                dl = 0;
            end
        end
        sent = sent + 11'd1;
        n_checks++; if (mm != 0) $display("FAIL pattern_model bad_cycles=%0d required=0", mm); else n_pass++;
        n_checks++; if (de_cnt != HA * VA) $display("FAIL pattern_de_count got=%0d required=%0d", de_cnt, HA * VA); else n_pass++;
        n_checks++; if (bad_line != 0) $display("FAIL pattern_de_per_line bad=%0d required=0", bad_line); else n_pass++;
        n_checks++; if (pix_bad != 0) $display("FAIL pattern_pix_when_no_de bad=%0d required=0", pix_bad); else n_pass++;
        n_checks++; if (p0_bad != 0 || p1_bad != 0) $display("FAIL pattern_first_bars bad0=%0d bad1=%0d required=0/0", p0_bad, p1_bad); else n_pass++;
        n_checks++; if (p7_bad != 0) $display("FAIL pattern_last_bar bad=%0d required=0", p7_bad); else n_pass++;
        n_checks++; if (bus.Frame_O_Cnt !== sent) $display("FAIL pattern_frame_cnt got=%0d required=%0d", bus.Frame_O_Cnt, sent); else n_pass++;
    endtask

    task automatic test_random();
        int dc, nd, rs, fr, bg, bw, mm, b0, be, fn, sa, exp_frames;
        for (int k = 0; k < 6; k++) begin
            fn = int'($urandom_range(0, 3));
            sa = (fn == 0 || $urandom_range(0, 1) == 1) ? int'($urandom_range(0, 3 * FL - 1)) : -1;
            exp_frames = (sa < 0) ? fn : sa / FL + 1;
            if (fn != 0 && exp_frames > fn) exp_frames = fn;
            watch(11'(fn), 1'b0, sa, 1'b1, dc, nd, rs, fr, bg, bw, mm, b0, be);
            sent = sent + 11'(exp_frames);
            n_checks++; if (mm != 0) $display("FAIL rand_model k=%0d fn=%0d stop=%0d bad_cycles=%0d required=0", k, fn, sa, mm); else n_pass++;
            n_checks++; if (rs != exp_frames) $display("FAIL rand_rises k=%0d got=%0d required=%0d", k, rs, exp_frames); else n_pass++;
            n_checks++; if (dc != exp_frames * FL) $display("FAIL rand_done_cycle k=%0d got=%0d required=%0d", k, dc, exp_frames * FL); else n_pass++;
            n_checks++; if (bus.Frame_O_Cnt !== sent) $display("FAIL rand_frame_cnt k=%0d got=%0d required=%0d", k, bus.Frame_O_Cnt, sent); else n_pass++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        bus.Start = 1'b0;
        bus.Stop = 1'b0;
        bus.Frame_Num = '0;
        test_reset();
        test_fixed_run();
        test_stop();
        test_start_ignored();
        test_start_stop_idle();
        test_reset_mid();
        test_pattern();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
